// File: rtl/turfio_cin_autotrain.sv
// CIN link-training sequencer: sweeps the IDELAY, centres on the widest eye of the
// training word, bitslips into nibble alignment and then requests parallelizer lock.
module turfio_cin_autotrain #(
    parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996,
    parameter int          TAP_STEP      = 8,
    parameter int          MAX_TAP       = 511,
    parameter int          MIN_EYE       = 32,
    parameter int          SETTLE_CYCLES = 16,
    parameter int          MAX_BITSLIP   = 7,
    parameter int          LOCK_TIMEOUT  = 1024
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_start,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_fail,
    output logic [1:0]  o_fail_code,
    output logic [8:0]  o_eye_start,
    output logic [8:0]  o_eye_width,
    output logic        o_en_vtc,
    output logic        o_delay_load,
    output logic [8:0]  o_delay_cntvaluein,
    output logic        o_capture_req,
    input  logic        i_capture_valid,
    input  logic [31:0] i_capture_data,
    output logic        o_bitslip_rst,
    output logic        o_bitslip,
    output logic        o_lock_req,
    input  logic        i_lock_status,
    output logic [3:0]  o_dbg_state
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_PREP    = 4'd1;
    localparam logic [3:0] S_LOAD    = 4'd2;
    localparam logic [3:0] S_SETTLE  = 4'd3;
    localparam logic [3:0] S_CAP     = 4'd4;
    localparam logic [3:0] S_CAPWAIT = 4'd5;
    localparam logic [3:0] S_EVAL    = 4'd6;
    localparam logic [3:0] S_CLOAD   = 4'd7;
    localparam logic [3:0] S_CSETTLE = 4'd8;
    localparam logic [3:0] S_SCAP    = 4'd9;
    localparam logic [3:0] S_SWAIT   = 4'd10;
    localparam logic [3:0] S_SLIP    = 4'd11;
    localparam logic [3:0] S_LOCK    = 4'd12;
    localparam logic [3:0] S_LWAIT   = 4'd13;
    localparam logic [3:0] S_DONE    = 4'd14;
    localparam logic [3:0] S_FAIL    = 4'd15;

    localparam logic [9:0]  L_STEP        = 10'(TAP_STEP);
    localparam logic [9:0]  L_MAX_TAP     = 10'(MAX_TAP);
    localparam logic [9:0]  L_MIN_EYE     = 10'(MIN_EYE);
    localparam logic [3:0]  L_MAX_SLIP    = 4'(MAX_BITSLIP);
    localparam logic [10:0] L_SETTLE_LAST = 11'(SETTLE_CYCLES - 1);
    localparam logic [10:0] L_LOCK_LAST   = 11'(LOCK_TIMEOUT - 1);
    localparam logic [63:0] L_PAT2        = {TRAIN_PATTERN, TRAIN_PATTERN};

    logic [3:0]  r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_fail;
    logic [1:0]  r_fail_code;
    logic [8:0]  r_eye_start;
    logic [8:0]  r_eye_width;
    logic        r_en_vtc;
    logic        r_delay_load;
    logic [8:0]  r_cntval;
    logic        r_capture_req;
    logic        r_bitslip_rst;
    logic        r_bitslip;
    logic        r_lock_req;
    logic [9:0]  r_tap;
    logic [9:0]  r_run_len;
    logic [9:0]  r_run_start;
    logic [9:0]  r_best_start;
    logic [9:0]  r_best_width;
    logic [3:0]  r_slips;
    logic [10:0] r_cnt;
    logic        r_good;

    logic        w_any_rot;
    logic        w_exact;
    logic [9:0]  w_next_tap;
    logic [9:0]  w_run_len_nx;
    logic [9:0]  w_run_start_nx;
    logic [9:0]  w_centre_raw;
    logic [9:0]  w_centre;
    logic [8:0]  w_width_sat;

    // During the sweep the word only has to be some nibble rotation of the pattern.
    always_comb begin
        w_any_rot = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (i_capture_data == L_PAT2[4*k +: 32]) begin
                w_any_rot = 1'b1;
            end
        end
    end

    assign w_exact        = (i_capture_data == TRAIN_PATTERN);
    assign w_next_tap     = r_tap + L_STEP;
    assign w_run_len_nx   = r_good ? (r_run_len + L_STEP) : 10'd0;
    assign w_run_start_nx = (r_good && (r_run_len == 10'd0)) ? r_tap : r_run_start;
    assign w_centre_raw   = r_best_start + {1'b0, r_best_width[9:1]};
    assign w_centre       = (w_centre_raw > L_MAX_TAP) ? L_MAX_TAP : w_centre_raw;
    assign w_width_sat    = (r_best_width > 10'd511) ? 9'd511 : r_best_width[8:0];

    // Capture handshake: capture_req is a one-cycle request; the sequencer then waits
    // indefinitely for a one-cycle capture_valid carrying the word (abort is the way out).
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_fail        <= 1'b0;
            r_fail_code   <= 2'd0;
            r_eye_start   <= 9'd0;
            r_eye_width   <= 9'd0;
            r_en_vtc      <= 1'b1;
            r_delay_load  <= 1'b0;
            r_cntval      <= 9'd0;
            r_capture_req <= 1'b0;
            r_bitslip_rst <= 1'b0;
            r_bitslip     <= 1'b0;
            r_lock_req    <= 1'b0;
            r_tap         <= 10'd0;
            r_run_len     <= 10'd0;
            r_run_start   <= 10'd0;
            r_best_start  <= 10'd0;
            r_best_width  <= 10'd0;
            r_slips       <= 4'd0;
            r_cnt         <= 11'd0;
            r_good        <= 1'b0;
        end else begin
            r_delay_load  <= 1'b0;
            r_capture_req <= 1'b0;
            r_bitslip_rst <= 1'b0;
            r_bitslip     <= 1'b0;
            r_lock_req    <= 1'b0;

            if (i_abort) begin
                r_state  <= S_IDLE;
                r_en_vtc <= 1'b1;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
                r_fail   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE, S_FAIL: begin
                        if (i_start) begin
                            r_state       <= S_PREP;
                            r_en_vtc      <= 1'b0;
                            r_bitslip_rst <= 1'b1;
                            r_tap         <= 10'd0;
                            r_run_len     <= 10'd0;
                            r_run_start   <= 10'd0;
                            r_best_start  <= 10'd0;
                            r_best_width  <= 10'd0;
                            r_fail_code   <= 2'd0;
                            r_done        <= 1'b0;
                            r_fail        <= 1'b0;
                            r_busy        <= 1'b1;
                        end else if ((r_state == S_DONE) && !i_lock_status) begin
                            r_state     <= S_FAIL;
                            r_done      <= 1'b0;
                            r_fail      <= 1'b1;
                            r_fail_code <= 2'd3;
                        end
                    end
                    S_PREP: begin
                        r_state <= S_LOAD;
                    end
                    S_LOAD: begin
                        r_delay_load <= 1'b1;
                        r_cntval     <= r_tap[8:0];
                        r_cnt        <= 11'd0;
                        r_state      <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (r_cnt == L_SETTLE_LAST) begin
                            r_state <= S_CAP;
                        end else begin
                            r_cnt <= r_cnt + 11'd1;
                        end
                    end
                    S_CAP: begin
                        r_capture_req <= 1'b1;
                        r_state       <= S_CAPWAIT;
                    end
                    S_CAPWAIT: begin
                        if (i_capture_valid) begin
                            r_good  <= w_any_rot;
                            r_state <= S_EVAL;
                        end
                    end
                    S_EVAL: begin
                        // Best eye is updated with the run including this point, so a
                        // run that reaches the last tap is still considered.
                        r_run_len   <= w_run_len_nx;
                        r_run_start <= w_run_start_nx;
                        if (w_run_len_nx > r_best_width) begin
                            r_best_width <= w_run_len_nx;
                            r_best_start <= w_run_start_nx;
                        end
                        if (w_next_tap > L_MAX_TAP) begin
                            r_state <= S_CLOAD;
                        end else begin
                            r_tap   <= w_next_tap;
                            r_state <= S_LOAD;
                        end
                    end
                    S_CLOAD: begin
                        if (r_best_width < L_MIN_EYE) begin
                            r_state     <= S_FAIL;
                            r_fail      <= 1'b1;
                            r_fail_code <= 2'd1;
                            r_busy      <= 1'b0;
                            r_en_vtc    <= 1'b1;
                        end else begin
                            r_delay_load <= 1'b1;
                            r_cntval     <= w_centre[8:0];
                            r_eye_start  <= r_best_start[8:0];
                            r_eye_width  <= w_width_sat;
                            r_slips      <= 4'd0;
                            r_cnt        <= 11'd0;
                            r_state      <= S_CSETTLE;
                        end
                    end
                    S_CSETTLE: begin
                        if (r_cnt == L_SETTLE_LAST) begin
                            r_state <= S_SCAP;
                        end else begin
                            r_cnt <= r_cnt + 11'd1;
                        end
                    end
                    S_SCAP: begin
                        r_capture_req <= 1'b1;
                        r_state       <= S_SWAIT;
                    end
                    S_SWAIT: begin
                        if (i_capture_valid) begin
                            if (w_exact) begin
                                r_state <= S_LOCK;
                            end else if (r_slips < L_MAX_SLIP) begin
                                r_bitslip <= 1'b1;
                                r_slips   <= r_slips + 4'd1;
                                r_cnt     <= 11'd0;
                                r_state   <= S_SLIP;
                            end else begin
                                r_state     <= S_FAIL;
                                r_fail      <= 1'b1;
                                r_fail_code <= 2'd2;
                                r_busy      <= 1'b0;
                                r_en_vtc    <= 1'b1;
                            end
                        end
                    end
                    S_SLIP: begin
                        if (r_cnt == L_SETTLE_LAST) begin
                            r_state <= S_SCAP;
                        end else begin
                            r_cnt <= r_cnt + 11'd1;
                        end
                    end
                    S_LOCK: begin
                        r_en_vtc   <= 1'b1;
                        r_lock_req <= 1'b1;
                        r_cnt      <= 11'd0;
                        r_state    <= S_LWAIT;
                    end
                    S_LWAIT: begin
                        if (i_lock_status) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == L_LOCK_LAST) begin
                            r_state     <= S_FAIL;
                            r_fail      <= 1'b1;
                            r_fail_code <= 2'd3;
                            r_busy      <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 11'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_fail             = r_fail;
    assign o_fail_code        = r_fail_code;
    assign o_eye_start        = r_eye_start;
    assign o_eye_width        = r_eye_width;
    assign o_en_vtc           = r_en_vtc;
    assign o_delay_load       = r_delay_load;
    assign o_delay_cntvaluein = r_cntval;
    assign o_capture_req      = r_capture_req;
    assign o_bitslip_rst      = r_bitslip_rst;
    assign o_bitslip          = r_bitslip;
    assign o_lock_req         = r_lock_req;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_turfio_cin_autotrain.sv
// Bench for turfio_cin_autotrain: a CIN link/parallelizer model answers the sequencer,
// and an eye-interval reference model predicts the training outcome.
module tb_turfio_cin_autotrain;

    localparam logic [31:0] PAT       = 32'hA55A6996;
    localparam int          TAP_STEP  = 8;
    localparam int          MAX_TAP   = 511;
    localparam int          MIN_EYE   = 32;
    localparam logic [3:0]  ST_IDLE   = 4'd0;
    localparam logic [3:0]  ST_SETTLE = 4'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        cap_valid = 1'b0;
    logic [31:0] cap_data = 32'd0;
    logic        lock_status = 1'b0;
    logic        busy, done, fail, en_vtc, delay_load, capture_req, bitslip_rst, bitslip, lock_req;
    logic [1:0]  fail_code;
    logic [8:0]  eye_start, eye_width, cntval;
    logic [3:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    // link model configuration
    int n_eyes = 0;
    int eye_lo[2];
    int eye_hi[2];
    int nib_off = 0;
    bit never_exact = 0;
    bit lock_mode = 1;
    bit force_unlock = 0;

    // observed activity
    int load_cnt, last_load, bitslip_cnt, bslrst_cnt, lockreq_cnt;

    // reference expectations
    int exp_code, exp_start, exp_width, exp_centre, exp_slips, exp_locks;

    turfio_cin_autotrain dut (
        .i_wb_clk           (clk),
        .i_wb_rst           (rst),
        .i_start            (start),
        .i_abort            (abort),
        .o_busy             (busy),
        .o_done             (done),
        .o_fail             (fail),
        .o_fail_code        (fail_code),
        .o_eye_start        (eye_start),
        .o_eye_width        (eye_width),
        .o_en_vtc           (en_vtc),
        .o_delay_load       (delay_load),
        .o_delay_cntvaluein (cntval),
        .o_capture_req      (capture_req),
        .i_capture_valid    (cap_valid),
        .i_capture_data     (cap_data),
        .o_bitslip_rst      (bitslip_rst),
        .o_bitslip          (bitslip),
        .o_lock_req         (lock_req),
        .i_lock_status      (lock_status),
        .o_dbg_state        (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input int n);
        logic [31:0] p;
        p = PAT;
        if (n == 0) return p;
        return (p >> n) | (p << (32 - n));
    endfunction

    function automatic bit is_rot(input logic [31:0] d);
        for (int k = 0; k < 8; k++) if (d == rotr(4 * k)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit tap_good(input int t);
        for (int i = 0; i < n_eyes; i++) if (t >= eye_lo[i] && t <= eye_hi[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] link_word(input int t, input int slip);
        logic [31:0] g;
        if (!tap_good(t)) begin
            g = $urandom;
            while (is_rot(g)) g = $urandom;
            return g;
        end
        if (never_exact) return rotr(12);
        return rotr(4 * ((nib_off - slip + 8) % 8));
    endfunction

    // Eye search as interval scan: every sweep point that opens an eye is extended to
    // its last good point; the first eye of maximal width wins.
    task automatic model_expect();
        int best_w, best_s, e;
        best_w = 0;
        best_s = 0;
        for (int s = 0; s <= MAX_TAP; s += TAP_STEP) begin
            if (tap_good(s) && (s == 0 || !tap_good(s - TAP_STEP))) begin
                e = s;
                while (e + TAP_STEP <= MAX_TAP && tap_good(e + TAP_STEP)) e += TAP_STEP;
                if (e - s + TAP_STEP > best_w) begin
                    best_w = e - s + TAP_STEP;
                    best_s = s;
                end
            end
        end
        exp_start  = best_s;
        exp_width  = best_w;
        exp_centre = (best_s + best_w / 2 > MAX_TAP) ? MAX_TAP : best_s + best_w / 2;
        if (best_w < MIN_EYE) begin
            exp_code = 1; exp_slips = 0; exp_locks = 0;
        end else if (never_exact) begin
            exp_code = 2; exp_slips = 7; exp_locks = 0;
        end else begin
            exp_code = lock_mode ? 0 : 3; exp_slips = nib_off; exp_locks = 1;
        end
    endtask

    // CIN link + parallelizer model, also watching pulse shape
    initial begin
        int cap_wait, lock_wait, cur_tap, slip;
        logic [4:0] pv, prev_pv;
        cap_wait = 0; lock_wait = 0; cur_tap = 0; slip = 0; prev_pv = '0;
        forever begin
            @(negedge clk);
            cap_valid = 1'b0;
            if (rst) begin
                cap_wait = 0; lock_wait = 0; prev_pv = '0; lock_status = 1'b0;
            end else begin
                pv = {delay_load, capture_req, bitslip_rst, bitslip, lock_req};
                if (pv != 5'd0) begin
                    checks++;
                    if ($countones(pv) > 1 || (pv & prev_pv) != 5'd0) begin
                        errors++;
                        $display("FAIL pulse_shape: pulses=%b previous=%b (want one-hot, one cycle)", pv, prev_pv);
                    end
                end
                prev_pv = pv;
                if (delay_load) begin cur_tap = int'(cntval); last_load = cur_tap; load_cnt++; end
                if (bitslip_rst) begin slip = 0; bslrst_cnt++; cap_wait = 0; lock_wait = 0; lock_status = 1'b0; end
                if (bitslip) begin slip = (slip + 1) % 8; bitslip_cnt++; end
                if (capture_req) cap_wait = $urandom_range(1, 4);
                else if (cap_wait > 0) begin
                    cap_wait--;
                    if (cap_wait == 0) begin cap_valid = 1'b1; cap_data = link_word(cur_tap, slip); end
                end
                if (lock_req) begin lockreq_cnt++; lock_wait = lock_mode ? $urandom_range(2, 10) : 0; end
                else if (lock_wait > 0) begin
                    lock_wait--;
                    if (lock_wait == 0) lock_status = 1'b1;
                end
                if (force_unlock) lock_status = 1'b0;
            end
        end
    end

    task automatic clear_counts();
        load_cnt = 0; last_load = -1; bitslip_cnt = 0; bslrst_cnt = 0; lockreq_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_and_wait(output bit ok);
        int n;
        clear_counts();
        pulse_start();
        ok = 1'b0;
        n = 0;
        while (!ok && n < 6000) begin
            @(negedge clk);
            n++;
            if (done || fail) ok = 1'b1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL run_timeout: no done/fail after %0d cycles", n); end
    endtask

    task automatic test_reset();
        logic [41:0] got, want;
        repeat (3) @(negedge clk);
        got  = {busy, done, fail, fail_code, eye_start, eye_width, en_vtc, delay_load, cntval,
                capture_req, bitslip_rst, bitslip, lock_req, dbg_state};
        want = {3'b000, 2'd0, 9'd0, 9'd0, 1'b1, 1'b0, 9'd0, 4'b0000, ST_IDLE};
        checks++;
        if (got !== want) begin errors++; $display("FAIL reset_outputs: got %h want %h", got, want); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dbg_state !== ST_IDLE || en_vtc !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle: state=%0d en_vtc=%0b busy=%0b want 0/1/0", dbg_state, en_vtc, busy);
        end
    endtask

    task automatic test_single_eye();
        bit ok;
        n_eyes = 1; eye_lo[0] = 200; eye_hi[0] = 296; nib_off = 2; never_exact = 0; lock_mode = 1;
        run_and_wait(ok);
        checks++;
        if (done !== 1'b1 || fail !== 1'b0 || fail_code !== 2'd0) begin
            errors++; $display("FAIL single_done: done=%0b fail=%0b code=%0d want 1/0/0", done, fail, fail_code);
        end
        checks++;
        if (eye_start !== 9'd200 || eye_width !== 9'd104) begin
            errors++; $display("FAIL single_eye: start=%0d width=%0d want 200/104", eye_start, eye_width);
        end
        checks++;
        if (last_load != 252 || load_cnt != 65) begin
            errors++; $display("FAIL single_centre: last_load=%0d loads=%0d want 252/65", last_load, load_cnt);
        end
        checks++;
        if (bitslip_cnt != 2 || lockreq_cnt != 1 || bslrst_cnt != 1) begin
            errors++; $display("FAIL single_pulses: slips=%0d locks=%0d bsrst=%0d want 2/1/1", bitslip_cnt, lockreq_cnt, bslrst_cnt);
        end
        checks++;
        if (en_vtc !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL single_vtc: en_vtc=%0b busy=%0b want 1/0", en_vtc, busy);
        end
    endtask

    task automatic test_lock_loss();
        force_unlock = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (fail !== 1'b1 || done !== 1'b0 || fail_code !== 2'd3) begin
            errors++; $display("FAIL lock_loss: fail=%0b done=%0b code=%0d want 1/0/3", fail, done, fail_code);
        end
        force_unlock = 1'b0;
    endtask

    task automatic test_tie_eyes();
        bit ok;
        n_eyes = 2; eye_lo[0] = 40; eye_hi[0] = 112; eye_lo[1] = 304; eye_hi[1] = 376;
        nib_off = $urandom_range(0, 7); never_exact = 0; lock_mode = 1;
        model_expect();
        run_and_wait(ok);
        checks++;
        if (eye_start !== 9'(exp_start) || eye_width !== 9'(exp_width) || last_load != exp_centre) begin
            errors++; $display("FAIL tie_eye: start=%0d width=%0d load=%0d want %0d/%0d/%0d",
                               eye_start, eye_width, last_load, exp_start, exp_width, exp_centre);
        end
        checks++;
        if (done !== 1'b1 || bitslip_cnt != exp_slips) begin
            errors++; $display("FAIL tie_lock: done=%0b slips=%0d want 1/%0d", done, bitslip_cnt, exp_slips);
        end
    endtask

    task automatic test_eye_boundaries();
        bit ok;
        int lo_tab[2] = '{472, 0};
        int hi_tab[2] = '{600, 24};
        for (int i = 0; i < 2; i++) begin
            n_eyes = 1; eye_lo[0] = lo_tab[i]; eye_hi[0] = hi_tab[i];
            nib_off = $urandom_range(0, 7); never_exact = 0; lock_mode = 1;
            model_expect();
            run_and_wait(ok);
            checks++;
            if ({done, fail, fail_code} !== {exp_code == 0, exp_code != 0, 2'(exp_code)} ||
                eye_start !== 9'(exp_start) || eye_width !== 9'(exp_width) || last_load != exp_centre) begin
                errors++; $display("FAIL boundary_%0d: code=%0d start=%0d width=%0d load=%0d want %0d/%0d/%0d/%0d",
                                   i, fail_code, eye_start, eye_width, last_load, exp_code, exp_start, exp_width, exp_centre);
            end
        end
    endtask

    task automatic test_random_eyes();
        bit ok;
        for (int i = 0; i < 3; i++) begin
            n_eyes = $urandom_range(1, 2);
            eye_lo[0] = $urandom_range(0, 300); eye_hi[0] = eye_lo[0] + $urandom_range(0, 150);
            eye_lo[1] = eye_hi[0] + $urandom_range(9, 100); eye_hi[1] = eye_lo[1] + $urandom_range(0, 150);
            nib_off = $urandom_range(0, 7); never_exact = 0; lock_mode = 1;
            model_expect();
            run_and_wait(ok);
            checks++;
            if ({done, fail, fail_code} !== {exp_code == 0, exp_code != 0, 2'(exp_code)}) begin
                errors++; $display("FAIL random_%0d_code: done=%0b fail=%0b code=%0d want code %0d", i, done, fail, fail_code, exp_code);
            end
            checks++;
            if (bitslip_cnt != exp_slips || lockreq_cnt != exp_locks ||
                (exp_code != 1 && (eye_start !== 9'(exp_start) || eye_width !== 9'(exp_width) || last_load != exp_centre))) begin
                errors++; $display("FAIL random_%0d_eye: start=%0d width=%0d load=%0d slips=%0d want %0d/%0d/%0d/%0d",
                                   i, eye_start, eye_width, last_load, bitslip_cnt, exp_start, exp_width, exp_centre, exp_slips);
            end
        end
    endtask

    task automatic test_no_eye();
        bit ok;
        n_eyes = 0; never_exact = 0; lock_mode = 1;
        run_and_wait(ok);
        checks++;
        if (fail !== 1'b1 || fail_code !== 2'd1 || done !== 1'b0) begin
            errors++; $display("FAIL no_eye_code: fail=%0b code=%0d done=%0b want 1/1/0", fail, fail_code, done);
        end
        checks++;
        if (bitslip_cnt != 0 || lockreq_cnt != 0 || load_cnt != 64 || en_vtc !== 1'b1) begin
            errors++; $display("FAIL no_eye_pulses: slips=%0d locks=%0d loads=%0d en_vtc=%0b want 0/0/64/1",
                               bitslip_cnt, lockreq_cnt, load_cnt, en_vtc);
        end
        n_eyes = 1; eye_lo[0] = 100; eye_hi[0] = 120;
        run_and_wait(ok);
        checks++;
        if (fail !== 1'b1 || fail_code !== 2'd1) begin
            errors++; $display("FAIL narrow_eye: fail=%0b code=%0d want 1/1", fail, fail_code);
        end
    endtask

    task automatic test_no_bitslip();
        bit ok;
        n_eyes = 1; eye_lo[0] = 200; eye_hi[0] = 296; never_exact = 1; lock_mode = 1;
        run_and_wait(ok);
        checks++;
        if (fail !== 1'b1 || fail_code !== 2'd2 || bitslip_cnt != 7 || lockreq_cnt != 0 || en_vtc !== 1'b1) begin
            errors++; $display("FAIL no_bitslip: fail=%0b code=%0d slips=%0d locks=%0d en_vtc=%0b want 1/2/7/0/1",
                               fail, fail_code, bitslip_cnt, lockreq_cnt, en_vtc);
        end
        never_exact = 0;
    endtask

    task automatic test_lock_timeout();
        int n;
        bit seen;
        n_eyes = 1; eye_lo[0] = 100; eye_hi[0] = 300; nib_off = 5; lock_mode = 0;
        clear_counts();
        pulse_start();
        seen = 1'b0; n = 0;
        while (!seen && n < 4000) begin @(negedge clk); n++; if (lock_req) seen = 1'b1; end
        n = 0;
        while (seen && !fail && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (!seen || n != 1024) begin
            errors++; $display("FAIL lock_timeout_len: lock_req_seen=%0b cycles=%0d want 1/1024", seen, n);
        end
        checks++;
        if (fail !== 1'b1 || fail_code !== 2'd3 || done !== 1'b0 || lockreq_cnt != 1) begin
            errors++; $display("FAIL lock_timeout_code: fail=%0b code=%0d done=%0b locks=%0d want 1/3/0/1",
                               fail, fail_code, done, lockreq_cnt);
        end
        lock_mode = 1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lo_tab[2] = '{120, 320};
        int hi_tab[2] = '{260, 480};
        for (int i = 0; i < 2; i++) begin
            n_eyes = 1; eye_lo[0] = lo_tab[i]; eye_hi[0] = hi_tab[i];
            nib_off = 4 + 2 * i; never_exact = 0; lock_mode = 1;
            model_expect();
            run_and_wait(ok);
            checks++;
            if (done !== 1'b1 || fail_code !== 2'd0 || eye_start !== 9'(exp_start) ||
                eye_width !== 9'(exp_width) || last_load != exp_centre || bitslip_cnt != exp_slips) begin
                errors++; $display("FAIL back_to_back_%0d: done=%0b start=%0d width=%0d load=%0d slips=%0d want 1/%0d/%0d/%0d/%0d",
                                   i, done, eye_start, eye_width, last_load, bitslip_cnt, exp_start, exp_width, exp_centre, exp_slips);
            end
        end
    endtask

    task automatic test_abort();
        n_eyes = 1; eye_lo[0] = 40; eye_hi[0] = 400;
        clear_counts();
        pulse_start();
        repeat (300) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || en_vtc !== 1'b0) begin
            errors++; $display("FAIL abort_sweeping: busy=%0b en_vtc=%0b want 1/0", busy, en_vtc);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (dbg_state !== ST_IDLE || en_vtc !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0 ||
            {delay_load, capture_req, bitslip_rst, bitslip, lock_req} !== 5'b0) begin
            errors++; $display("FAIL abort_idle: state=%0d en_vtc=%0b busy=%0b done=%0b fail=%0b want 0/1/0/0/0, no pulse",
                               dbg_state, en_vtc, busy, done, fail);
        end
        checks++;
        if (eye_start !== 9'(exp_start) || eye_width !== 9'(exp_width)) begin
            errors++; $display("FAIL abort_eye_kept: start=%0d width=%0d want %0d/%0d", eye_start, eye_width, exp_start, exp_width);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_start_abort();
        clear_counts();
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dbg_state !== ST_IDLE || busy !== 1'b0 || bslrst_cnt != 0) begin
            errors++; $display("FAIL start_abort: state=%0d busy=%0b bitslip_rst=%0d want 0/0/0", dbg_state, busy, bslrst_cnt);
        end
    endtask

    task automatic test_reset_mid_settle();
        int n;
        logic [41:0] got, want;
        clear_counts();
        pulse_start();
        n = 0;
        while (dbg_state !== ST_SETTLE && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (dbg_state !== ST_SETTLE) begin errors++; $display("FAIL settle_reach: state=%0d want %0d", dbg_state, ST_SETTLE); end
        #2 rst = 1'b1;
        #1;
        got  = {busy, done, fail, fail_code, eye_start, eye_width, en_vtc, delay_load, cntval,
                capture_req, bitslip_rst, bitslip, lock_req, dbg_state};
        want = {3'b000, 2'd0, 9'd0, 9'd0, 1'b1, 1'b0, 9'd0, 4'b0000, ST_IDLE};
        checks++;
        if (got !== want) begin errors++; $display("FAIL async_reset: got %h want %h", got, want); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_single_eye();
        test_lock_loss();
        test_tie_eyes();
        test_eye_boundaries();
        test_random_eyes();
        test_no_eye();
        test_no_bitslip();
        test_lock_timeout();
        test_back_to_back();
        test_abort();
        test_start_abort();
        test_reset_mid_settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
